// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// Module : mole_pkg
// Brief  : Shared types and constants for the mole game core and its LFSR.
// Rev    : 1.0 - initial release
// ============================================================================
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPAWN  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_GAP    = 3'd3,
        ST_OVER   = 3'd4
    } mole_state_t;

    // Low byte is nonzero so any truncation to 8..32 bits stays a legal seed.
    localparam logic [31:0] c_lfsr_seed = 32'hACE1_35F7;

    // Right-shift Galois feedback masks for maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       lfsr_taps = 32'h0000_00B8;
            9:       lfsr_taps = 32'h0000_0110;
            10:      lfsr_taps = 32'h0000_0240;
            11:      lfsr_taps = 32'h0000_0500;
            12:      lfsr_taps = 32'h0000_0829;
            13:      lfsr_taps = 32'h0000_100D;
            14:      lfsr_taps = 32'h0000_2015;
            15:      lfsr_taps = 32'h0000_6000;
            16:      lfsr_taps = 32'h0000_B400;
            17:      lfsr_taps = 32'h0001_2000;
            18:      lfsr_taps = 32'h0002_0400;
            19:      lfsr_taps = 32'h0004_0023;
            20:      lfsr_taps = 32'h0009_0000;
            21:      lfsr_taps = 32'h0014_0000;
            22:      lfsr_taps = 32'h0030_0000;
            23:      lfsr_taps = 32'h0042_0000;
            24:      lfsr_taps = 32'h00E1_0000;
            25:      lfsr_taps = 32'h0120_0000;
            26:      lfsr_taps = 32'h0200_0023;
            27:      lfsr_taps = 32'h0400_0013;
            28:      lfsr_taps = 32'h0900_0000;
            29:      lfsr_taps = 32'h1400_0000;
            30:      lfsr_taps = 32'h2000_0029;
            31:      lfsr_taps = 32'h4800_0000;
            32:      lfsr_taps = 32'h8020_0003;
            default: lfsr_taps = 32'h0000_B400;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// ============================================================================
// Module : mole_lfsr
// Brief  : Free-running maximal-length Galois LFSR with zero-state recovery.
// Rev    : 1.0 - initial release
// ============================================================================
module mole_lfsr
    import mole_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = c_lfsr_seed[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] q
);

    localparam logic [31:0]      c_taps_full = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] c_taps      = c_taps_full[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (r_q == '0) begin
            r_q <= SEED;
        end else begin
            r_q <= (r_q >> 1) ^ (r_q[0] ? c_taps : '0);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mole_game_core.sv
`default_nettype none
// ============================================================================
// Module : mole_game_core
// Brief  : Whack-a-mole sequencer: spawns moles, times windows, scores hits.
// Rev    : 1.0 - initial release
// ============================================================================
module mole_game_core
    import mole_pkg::*;
#(
    parameter int N_MOLES        = 8,
    parameter int LFSR_W         = 16,
    parameter int TICK_DIV       = 50000,
    parameter int WIN_BASE       = 40,
    parameter int WIN_STEP       = 4,
    parameter int WIN_MIN        = 8,
    parameter int GAP_TICKS      = 5,
    parameter int LIVES          = 3,
    parameter int HITS_PER_LEVEL = 8,
    parameter int MAX_LEVEL      = 7,
    parameter int SCORE_W        = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           hit_valid,
    input  logic [$clog2(N_MOLES)-1:0]     hit_idx,
    output logic [N_MOLES-1:0]             mole_led,
    output logic [SCORE_W-1:0]             score,
    output logic [$clog2(LIVES+1)-1:0]     lives,
    output logic [$clog2(MAX_LEVEL+1)-1:0] level,
    output logic                           game_over
);

    localparam int IDX_W = $clog2(N_MOLES);
    localparam int LIV_W = $clog2(LIVES + 1);
    localparam int LVL_W = $clog2(MAX_LEVEL + 1);
    localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WIN_W = $clog2(((WIN_BASE > WIN_MIN) ? WIN_BASE : WIN_MIN) + 1);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [PS_W-1:0]  c_ps_last   = PS_W'(TICK_DIV - 1);
    localparam logic [LIV_W-1:0] c_lives     = LIV_W'(LIVES);
    localparam logic [LVL_W-1:0] c_level_max = LVL_W'(MAX_LEVEL);
    localparam logic [HIT_W-1:0] c_hits_last = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [GAP_W-1:0] c_gap_load  = GAP_W'(GAP_TICKS);
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(N_MOLES - 1);

    mole_state_t        r_state,     w_state_next;
    logic [PS_W-1:0]    r_prescale,  w_prescale_next;
    logic [WIN_W-1:0]   r_win,       w_win_next;
    logic [GAP_W-1:0]   r_gap,       w_gap_next;
    logic [HIT_W-1:0]   r_hits,      w_hits_next;
    logic [IDX_W-1:0]   r_mole_idx,  w_mole_idx_next;
    logic [N_MOLES-1:0] r_mole_led,  w_mole_led_next;
    logic [SCORE_W-1:0] r_score,     w_score_next;
    logic [LIV_W-1:0]   r_lives,     w_lives_next;
    logic [LVL_W-1:0]   r_level,     w_level_next;
    logic               r_game_over;

    logic [LFSR_W-1:0]  w_lfsr_q;
    logic [IDX_W-1:0]   w_rand_idx;
    logic [IDX_W-1:0]   w_spawn_idx;
    logic [N_MOLES-1:0] w_spawn_led;
    logic [WIN_W-1:0]   w_win_load;
    logic               w_running;
    logic               w_tick;
    logic               w_timeout;
    logic               w_hit_ok;
    logic               w_hit_bad;

    mole_lfsr #(
        .WIDTH (LFSR_W),
        .SEED  (c_lfsr_seed[LFSR_W-1:0])
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (w_lfsr_q)
    );

    // r_mole_idx is never cleared, so it doubles as the previous mole.
    assign w_rand_idx  = IDX_W'(w_lfsr_q % LFSR_W'(N_MOLES));
    assign w_spawn_idx = (w_rand_idx != r_mole_idx) ? w_rand_idx :
                         (w_rand_idx == c_idx_last) ? '0 : w_rand_idx + 1'b1;
    assign w_spawn_led = {{(N_MOLES-1){1'b0}}, 1'b1} << w_spawn_idx;

    assign w_running = (r_state == ST_SPAWN) || (r_state == ST_ACTIVE) || (r_state == ST_GAP);
    assign w_tick    = w_running && (r_prescale == c_ps_last);
    assign w_timeout = w_tick && (r_win == WIN_W'(1));
    assign w_hit_ok  = hit_valid && (hit_idx == r_mole_idx);
    assign w_hit_bad = hit_valid && (hit_idx != r_mole_idx);

    always_comb begin
        int v_win;
        v_win = WIN_BASE - int'(r_level) * WIN_STEP;
        if (v_win < WIN_MIN) v_win = WIN_MIN;
        w_win_load = WIN_W'(v_win);
    end

    always_comb begin
        w_state_next    = r_state;
        w_prescale_next = r_prescale;
        w_win_next      = r_win;
        w_gap_next      = r_gap;
        w_hits_next     = r_hits;
        w_mole_idx_next = r_mole_idx;
        w_mole_led_next = r_mole_led;
        w_score_next    = r_score;
        w_lives_next    = r_lives;
        w_level_next    = r_level;

        if (w_running) w_prescale_next = w_tick ? '0 : r_prescale + 1'b1;

        if (start) begin
            w_state_next    = ST_SPAWN;
            w_prescale_next = '0;
            w_hits_next     = '0;
            w_mole_led_next = '0;
            w_score_next    = '0;
            w_lives_next    = c_lives;
            w_level_next    = '0;
        end else begin
            case (r_state)
                ST_SPAWN: begin
                    w_mole_idx_next = w_spawn_idx;
                    w_mole_led_next = w_spawn_led;
                    w_win_next      = w_win_load;
                    w_state_next    = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // A correct hit wins over a coinciding timeout tick.
                    if (w_hit_ok) begin
                        if (r_score != {SCORE_W{1'b1}}) w_score_next = r_score + 1'b1;
                        if (r_hits == c_hits_last) begin
                            w_hits_next = '0;
                            if (r_level != c_level_max) w_level_next = r_level + 1'b1;
                        end else begin
                            w_hits_next = r_hits + 1'b1;
                        end
                        w_mole_led_next = '0;
                        w_gap_next      = c_gap_load;
                        w_state_next    = ST_GAP;
                    end else begin
                        if (w_tick) w_win_next = r_win - 1'b1;
                        if (w_hit_bad || w_timeout) begin
                            w_lives_next = r_lives - 1'b1;
                            if (r_lives == LIV_W'(1)) begin
                                w_mole_led_next = '0;
                                w_state_next    = ST_OVER;
                            end else if (w_timeout) begin
                                w_mole_led_next = '0;
                                w_gap_next      = c_gap_load;
                                w_state_next    = ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_gap <= GAP_W'(1)) w_state_next = ST_SPAWN;
                        else                    w_gap_next   = r_gap - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prescale  <= '0;
            r_win       <= '0;
            r_gap       <= '0;
            r_hits      <= '0;
            r_mole_idx  <= '0;
            r_mole_led  <= '0;
            r_score     <= '0;
            r_lives     <= c_lives;
            r_level     <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_prescale  <= w_prescale_next;
            r_win       <= w_win_next;
            r_gap       <= w_gap_next;
            r_hits      <= w_hits_next;
            r_mole_idx  <= w_mole_idx_next;
            r_mole_led  <= w_mole_led_next;
            r_score     <= w_score_next;
            r_lives     <= w_lives_next;
            r_level     <= w_level_next;
            r_game_over <= (w_state_next == ST_OVER);
        end
    end

    assign mole_led  = r_mole_led;
    assign score     = r_score;
    assign lives     = r_lives;
    assign level     = r_level;
    assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_mole_game_core.sv
`default_nettype none
// ============================================================================
// Module : tb_mole_game_core
// Brief  : Directed self-checking bench for mole_game_core (small game config).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mole_game_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       hit_valid;
    logic [1:0] hit_idx;
    logic [3:0] mole_led;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] level;
    logic       game_over;

    always #5 clk = ~clk;

    mole_game_core #(
        .N_MOLES(4), .LFSR_W(16), .TICK_DIV(4), .WIN_BASE(6), .WIN_STEP(2), .WIN_MIN(2),
        .GAP_TICKS(2), .LIVES(3), .HITS_PER_LEVEL(2), .MAX_LEVEL(7), .SCORE_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit_valid(hit_valid), .hit_idx(hit_idx),
        .mole_led(mole_led), .score(score), .lives(lives), .level(level), .game_over(game_over)
    );

    typedef enum int {OP_START, OP_HIT, OP_MISS, OP_TIMEOUT} op_e;
    typedef struct {
        op_e op;
        int  score;
        int  lives;
        int  level;
        int  over;
    } vec_t;

    vec_t       vecs[9];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         idx, prev, cyc, lit;
    logic [3:0] led_save;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int led_idx(input logic [3:0] led);
        int r;
        r = -1;
        for (int k = 0; k < 4; k++) if (led[k]) r = k;
        return r;
    endfunction

    task automatic wait_mole(output int w_idx);
        int n;
        n = 0;
        w_idx = -1;
        while (mole_led == 4'b0 && n < 200) begin
            step();
            n++;
        end
        if (mole_led == 4'b0) check("wait_mole_timeout", 0, 1);
        else begin
            check("mole_onehot", $countones(mole_led), 1);
            w_idx = led_idx(mole_led);
        end
    endtask

    // Number of samples with a lit mole, starting at the current sample.
    task automatic wait_clear(output int n);
        n = 0;
        while (mole_led != 4'b0 && n < 200) begin
            n++;
            step();
        end
        if (mole_led != 4'b0) check("wait_clear_timeout", 0, 1);
    endtask

    task automatic hit(input int h);
        hit_valid = 1'b1;
        hit_idx   = 2'(h);
        step();
        hit_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_status(input string tag, input int s, input int l, input int lv, input int ov);
        check({tag, "_score"}, score, s);
        check({tag, "_lives"}, lives, l);
        check({tag, "_level"}, level, lv);
        check({tag, "_over"},  game_over, ov);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{OP_START,   0, 3, 0, 0};
        vecs[1] = '{OP_HIT,     1, 3, 0, 0};
        vecs[2] = '{OP_HIT,     2, 3, 1, 0};
        vecs[3] = '{OP_MISS,    2, 2, 1, 0};
        vecs[4] = '{OP_HIT,     3, 2, 1, 0};
        vecs[5] = '{OP_TIMEOUT, 3, 1, 1, 0};
        vecs[6] = '{OP_HIT,     4, 1, 2, 0};
        vecs[7] = '{OP_TIMEOUT, 4, 0, 2, 1};
        vecs[8] = '{OP_START,   0, 3, 0, 0};

        rst_n = 1'b0; start = 1'b0; hit_valid = 1'b0; hit_idx = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", mole_led, 0);
        check_status("rst", 0, 3, 0, 0);
        rst_n = 1'b1;
        repeat (5) step();
        check("idle_led", mole_led, 0);

        for (int i = 0; i < 9; i++) begin
            case (vecs[i].op)
                OP_START: begin
                    pulse_start();
                    check($sformatf("v%0d_start_led", i), mole_led, 0);
                end
                OP_HIT: begin
                    wait_mole(idx);
                    hit(idx);
                    check($sformatf("v%0d_hit_led", i), mole_led, 0);
                end
                OP_MISS: begin
                    wait_mole(idx);
                    led_save = mole_led;
                    hit((idx + 1) % 4);
                    check($sformatf("v%0d_miss_led", i), mole_led, led_save);
                end
                default: begin
                    wait_mole(idx);
                    wait_clear(cyc);
                    step();
                    check($sformatf("v%0d_timeout_led", i), mole_led, 0);
                end
            endcase
            check_status($sformatf("v%0d", i), vecs[i].score, vecs[i].lives,
                         vecs[i].level, vecs[i].over);
        end

        // Level-0 window from start: lit for exactly 23 cycles; a wrong hit does not stop it.
        pulse_start();
        check("s1_led_after_start", mole_led, 0);
        step();
        check("s1_spawn_onehot", $countones(mole_led), 1);
        idx = led_idx(mole_led);
        led_save = mole_led;
        lit = 1;
        repeat (3) begin step(); lit++; end
        hit((idx + 1) % 4);
        lit++;
        check("s1_wrong_lives", lives, 2);
        check("s1_wrong_led", mole_led, led_save);
        while (mole_led != 4'b0 && lit < 100) begin
            step();
            if (mole_led != 4'b0) lit++;
        end
        check("s1_window_l0_cycles", lit, 23);
        check("s1_timeout_lives", lives, 1);

        // Correct hit on the very timeout tick counts as a hit only.
        pulse_start();
        step();
        idx = led_idx(mole_led);
        repeat (22) step();
        check("s2_still_lit", $countones(mole_led), 1);
        hit(idx);
        check("s2_tie_score", score, 1);
        check("s2_tie_lives", lives, 3);
        check("s2_tie_led", mole_led, 0);

        // Level-1 window shrinks to 4 ticks, then three timeouts end the game.
        pulse_start();
        repeat (2) begin wait_mole(idx); hit(idx); end
        check("s3_score", score, 2);
        check("s3_level", level, 1);
        wait_mole(idx);
        wait_clear(cyc);
        check("s3_window_l1_in_13_16", int'(cyc >= 13 && cyc <= 16), 1);
        step();
        check("s3_lives_a", lives, 2);
        wait_mole(idx); wait_clear(cyc); step();
        check("s3_lives_b", lives, 1);
        wait_mole(idx); wait_clear(cyc); step();
        check_status("s3_over", 2, 0, 1, 1);
        check("s3_over_led", mole_led, 0);
        hit(0);
        lit = 0;
        repeat (20) begin step(); if (mole_led != 4'b0) lit++; end
        check("s3_over_stays_dark", lit, 0);
        check_status("s3_over_hold", 2, 0, 1, 1);

        // Restart in the middle of an active window.
        pulse_start();
        wait_mole(idx);
        hit(idx);
        wait_mole(idx);
        step();
        pulse_start();
        check("s4_restart_led", mole_led, 0);
        check_status("s4_restart", 0, 3, 0, 0);
        step();
        check("s4_respawn_onehot", $countones(mole_led), 1);

        // 100 consecutive spawns, never the same index twice in a row.
        pulse_start();
        prev = -1;
        for (int i = 0; i < 100; i++) begin
            wait_mole(idx);
            if (i > 0) check($sformatf("s5_repeat_%0d", i), int'(idx == prev), 0);
            prev = idx;
            hit(idx);
            if (i == 0) begin
                hit(idx);
                check("s5_gap_hit_ignored", score, 1);
            end
        end
        check("s5_score", score, 100);
        check("s5_level_sat", level, 7);
        check("s5_lives", lives, 3);

        // Asynchronous reset mid-game, then no resumption.
        wait_mole(idx);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_led", mole_led, 0);
        check_status("s6_async", 0, 3, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lit = 0;
        repeat (40) begin step(); if (mole_led != 4'b0) lit++; end
        check("s6_no_resume", lit, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mole_game_core.md
MOLE_GAME_CORE -- requirements
Module: mole_game_core

Interface
REQ-001 Parameter N_MOLES, default 8, sets the number of mole lamps; legal range 2..16.
REQ-002 Parameter LFSR_W, default 16, sets the random generator width; legal range 8..32.
REQ-003 Parameter TICK_DIV, default 50000, sets clk cycles per game tick.
REQ-004 Parameter WIN_BASE / WIN_STEP / WIN_MIN, defaults 40 / 4 / 8, set mole-up window ticks at level 0, the reduction per level, and the floor.
REQ-005 Parameter GAP_TICKS, default 5, sets dark ticks between moles.
REQ-006 Parameters LIVES, HITS_PER_LEVEL, MAX_LEVEL and SCORE_W, defaults 3 / 8 / 7 / 8, set starting lives, the hits needed per level-up, the level ceiling and the score width.
REQ-007 clk  in  1  single system clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  one-cycle pulse that begins or restarts a game.
REQ-010 hit_valid  in  1  one-cycle pulse flagging a debounced key press.
REQ-011 hit_idx  in  clog2(N_MOLES)  index of the key pressed, qualified by hit_valid.
REQ-012 mole_led  out  N_MOLES  one-hot lit mole, or all-zero.
REQ-013 score  out  SCORE_W  correct-hit count in binary.
REQ-014 lives  out  clog2(LIVES+1)  remaining lives.
REQ-015 level  out  clog2(MAX_LEVEL+1)  current difficulty level.
REQ-016 game_over  out  1  high while in OVER.

Function
REQ-017 FSM states: IDLE, SPAWN, ACTIVE, GAP, OVER; IDLE is the reset state.
REQ-018 In any state, start loads score=0, lives=LIVES, level=0, clears hit counter, prescaler and mole_led, then enters SPAWN next cycle.
REQ-019 Prescaler runs only in SPAWN/ACTIVE/GAP and emits a one-cycle tick when its count reaches TICK_DIV-1, then wraps to 0.
REQ-020 LFSR is a maximal-length Galois LFSR that steps every clk regardless of state; a zero state reloads the nonzero seed on the next cycle.
REQ-021 SPAWN lasts one cycle: idx = LFSR mod N_MOLES; if idx equals the previous mole, use (idx+1) mod N_MOLES; mole_led is one-hot(idx) from the next cycle onward.
REQ-022 On SPAWN exit, the window counter loads max(WIN_BASE - level*WIN_STEP, WIN_MIN).
REQ-023 ACTIVE, hit_valid with hit_idx equal to the mole: score+1 (saturating at 2^SCORE_W-1), hit counter+1, mole_led cleared, go to GAP; all updates take effect next cycle.
REQ-024 ACTIVE, hit_valid with a wrong hit_idx: lives-1; the mole stays lit and the window keeps running.
REQ-025 ACTIVE, a tick with window counter at 1: lives-1, mole_led cleared, go to GAP; otherwise each tick decrements the window counter.
REQ-026 A correct hit in the same cycle as a timeout tick counts as a hit only; there is no life loss.
REQ-027 When the hit counter reaches HITS_PER_LEVEL, the counter clears and level increments, saturating at MAX_LEVEL; the new level applies from the next SPAWN.
REQ-028 Whenever lives reaches 0, go to OVER next cycle with mole_led=0; score and level hold.
REQ-029 GAP waits GAP_TICKS ticks, then goes to SPAWN.
REQ-030 hit_valid is ignored in IDLE, SPAWN, GAP and OVER.
REQ-031 OVER is left only by start or reset.

Reset
REQ-032 While rst_n is low: state=IDLE, mole_led=0, score=0, lives=LIVES, level=0, game_over=0, counters=0, LFSR=seed; effect is immediate and asynchronous.
REQ-033 Reset release mid-game leaves the block in IDLE; it never resumes the interrupted game.

Structure
REQ-034 Package mole_pkg holds the FSM state enum, the default LFSR seed and the tap masks per LFSR_W.
REQ-035 The LFSR is the sub-module mole_lfsr (params WIDTH, SEED; ports clk, rst_n, q); all other logic is flat.
REQ-036 All outputs are registered.

Verification (N_MOLES=4, TICK_DIV=4, WIN_BASE=6, WIN_STEP=2, WIN_MIN=2, GAP_TICKS=2, LIVES=3, HITS_PER_LEVEL=2)
REQ-037 Reset, then start: mole_led goes one-hot within 2 cycles; score=0, lives=3, level=0.
REQ-038 A correct hit on each of 2 moles gives score=2 and level=1; the next window is 4 ticks (16 cycles).
REQ-039 No hits for 3 windows: lives steps 3->2->1->0, then game_over=1, mole_led=0 and score is held.
REQ-040 A wrong hit_idx in ACTIVE gives lives-1 while mole_led is unchanged; a correct hit timed on the timeout tick gives score+1 and lives unchanged.
REQ-041 start asserted in OVER, and mid-ACTIVE, reinitialises the game; 100 consecutive spawns never repeat the same index twice in a row.
